// File: rtl/systolic_pkg.sv
// Shared types and constant helpers for the systolic matmul engine.
// Holds FSM encodings, default accumulator width and latency math.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int acc_w_def(
    input int width,
    input int kdim
  );
    return 2 * width + $clog2(kdim) + 4;
  endfunction

  function automatic int lat(
    input int kdim,
    input int rows,
    input int cols
  );
    return kdim + rows + cols;
  endfunction

  function automatic int feed_len(
    input int kdim,
    input int rows,
    input int cols
  );
    return kdim + ((rows > cols) ? rows : cols) - 1;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Operand/result handshake bundle for the matmul engine.
// master drives operands and out_ready; slave is the engine.
interface systolic_matmul_engine_if
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int KDIM  = 4,
  parameter int ACC_W = acc_w_def(WIDTH, KDIM)
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic                        acc_mode;
  logic [WIDTH*ROWS*KDIM-1:0]  a_mat;
  logic [WIDTH*KDIM*COLS-1:0]  b_mat;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACC_W*ROWS*COLS-1:0]  result;
  logic                        busy;

  modport master (
    output in_valid, acc_mode, a_mat, b_mat, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, acc_mode, a_mat, b_mat, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/mac_cell.sv
// Output-stationary PE: forwards A right / B down, accumulates A*B.
// Ports: en (MAC), clr/load (job start), preload, a/b in/out, acc.
module mac_cell #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    load,
  input  logic [ACC_W-1:0]        preload,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] a_out,
  output logic signed [WIDTH-1:0] b_out,
  output logic [ACC_W-1:0]        acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic [ACC_W-1:0]          prod_x;

  assign prod   = a_in * b_in;
  assign prod_x = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr || load) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= clr ? '0 : preload;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_x;
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// ROWSxCOLS output-stationary systolic array computing C (+)= A*B.
// Ports: clk, rst_n (sync, active-low), bus (slave handshake bundle).
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int KDIM  = 4,
  parameter int ACC_W = acc_w_def(WIDTH, KDIM)
) (
  input logic                     clk,
  input logic                     rst_n,
  systolic_matmul_engine_if.slave bus
);

  localparam int LAT    = lat(KDIM, ROWS, COLS);
  localparam int FEED_N = feed_len(KDIM, ROWS, COLS);
  localparam int CW     = $clog2(LAT + 1);

  state_t                     state_q;
  state_t                     state_d;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cnt_d;
  logic                       hs;
  logic                       done_ld;
  logic                       en;
  logic [WIDTH*ROWS*KDIM-1:0] a_q;
  logic [WIDTH*KDIM*COLS-1:0] b_q;
  logic [ACC_W*ROWS*COLS-1:0] res_q;

  logic signed [WIDTH-1:0] a_feed [ROWS];
  logic signed [WIDTH-1:0] b_feed [COLS];
  logic signed [WIDTH-1:0] a_h    [ROWS][COLS];
  logic signed [WIDTH-1:0] b_h    [ROWS][COLS];
  logic signed [WIDTH-1:0] a_o    [ROWS][COLS];
  logic signed [WIDTH-1:0] b_o    [ROWS][COLS];
  logic [ACC_W-1:0]        acc    [ROWS][COLS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hs      = 1'b0;
    done_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          hs      = 1'b1;
          state_d = FEED;
          cnt_d   = '0;
        end
      end
      FEED: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FEED_N - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // last MAC of the far corner PE has landed by now
        if (cnt_q == CW'(LAT - 1)) begin
          state_d = DONE;
          done_ld = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (hs) begin
      a_q <= bus.a_mat;
      b_q <= bus.b_mat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (done_ld) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          res_q[(r*COLS+c)*ACC_W +: ACC_W] <= acc[r][c];
    end
  end

  // skewed injection: row r gets a(r,t-r), column c gets b(t-c,c)
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      a_feed[r] = '0;
      for (int k = 0; k < KDIM; k++)
        if (state_q == FEED && cnt_q == CW'(r + k))
          a_feed[r] = a_q[(r*KDIM+k)*WIDTH +: WIDTH];
    end
    for (int c = 0; c < COLS; c++) begin
      b_feed[c] = '0;
      for (int k = 0; k < KDIM; k++)
        if (state_q == FEED && cnt_q == CW'(c + k))
          b_feed[c] = b_q[(k*COLS+c)*WIDTH +: WIDTH];
    end
  end

  assign en = (state_q == FEED) || (state_q == DRAIN);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_al
        assign a_h[r][c] = a_feed[r];
      end else begin : g_ai
        assign a_h[r][c] = a_o[r][c-1];
      end
      if (r == 0) begin : g_bt
        assign b_h[r][c] = b_feed[c];
      end else begin : g_bi
        assign b_h[r][c] = b_o[r-1][c];
      end
      mac_cell #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (hs && !bus.acc_mode),
        .load    (hs && bus.acc_mode),
        .preload (res_q[(r*COLS+c)*ACC_W +: ACC_W]),
        .a_in    (a_h[r][c]),
        .b_in    (b_h[r][c]),
        .a_out   (a_o[r][c]),
        .b_out   (b_o[r][c]),
        .acc     (acc[r][c])
      );
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;

endmodule
